// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control and mul/div handshake
// for the five-stage pipeline, with saturating stall/redirect counters.
module pipeline_hazard_ctrl #(
  parameter int MD_MAX_CYCLES = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_addrD,
  input  logic [4:0]       rs2_addrD,
  input  logic [4:0]       rs1_addrE,
  input  logic [4:0]       rs2_addrE,
  input  logic [4:0]       rdE,
  input  logic             MemReadE,
  input  logic             MulDivE,
  input  logic             PCSrcE,
  input  logic [4:0]       rdM,
  input  logic             RegWriteM,
  input  logic [4:0]       rdW,
  input  logic             RegWriteW,
  input  logic             md_done,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             ID_EX_Stall,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             md_start,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int MW = $clog2(MD_MAX_CYCLES);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [MW-1:0] md_cnt;
  logic md_last, hold, redirect, lu, luse;
  assign md_last = md_cnt == MW'(MD_MAX_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      md_cnt     <= '0;
      md_timeout <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && MulDivE) md_cnt <= '0;
      else if (state == BUSY && !md_done && !md_last) md_cnt <= md_cnt + MW'(1);
      if (state == BUSY && !md_done && md_last) md_timeout <= 1'b1;
      if (StallF && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && MulDivE) state_nx = BUSY;
    if (state == BUSY && (md_done || md_last)) state_nx = IDLE;
  end
  // A timeout cycle releases the hold just like md_done so EX/MEM can advance.
  always_comb begin
    hold         = (state == BUSY) ? (!md_done && !md_last) : MulDivE;
    lu           = MemReadE && rdE != 5'd0 && (rdE == rs1_addrD || rdE == rs2_addrD);
    redirect     = !hold && PCSrcE;
    luse         = !hold && !PCSrcE && lu;
    StallF       = hold || luse;
    StallD       = hold || luse;
    FlushD       = redirect;
    ID_EX_Stall  = hold;
    ID_EX_Flush  = redirect || luse;
    EX_MEM_Flush = hold;
    md_start     = state == IDLE && MulDivE;
    ForwardAE    = (RegWriteM && rdM != 5'd0 && rdM == rs1_addrE) ? 2'b10 :
                   (RegWriteW && rdW != 5'd0 && rdW == rs1_addrE) ? 2'b01 : 2'b00;
    ForwardBE    = (RegWriteM && rdM != 5'd0 && rdM == rs2_addrE) ? 2'b10 :
                   (RegWriteW && rdW != 5'd0 && rdW == rs2_addrE) ? 2'b01 : 2'b00;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table for combinational controls plus
// directed sequences for the mul/div handshake, timeout, reset and saturation.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rdE, rdM, rdW;
  logic MemReadE, MulDivE, PCSrcE, RegWriteM, RegWriteW, md_done;
  logic StallF, StallD, FlushD, ID_EX_Stall, ID_EX_Flush, EX_MEM_Flush, md_start, md_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] stall_cnt, flush_cnt;
  int tests = 0, fails = 0;

  pipeline_hazard_ctrl #(.MD_MAX_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD),
    .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE), .rdE(rdE), .MemReadE(MemReadE),
    .MulDivE(MulDivE), .PCSrcE(PCSrcE), .rdM(rdM), .RegWriteM(RegWriteM), .rdW(rdW),
    .RegWriteW(RegWriteW), .md_done(md_done), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .ID_EX_Stall(ID_EX_Stall), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Flush(EX_MEM_Flush), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .md_start(md_start), .md_timeout(md_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] r1d, r2d, r1e, r2e, rde;
    logic       mr, pc;
    logic [4:0] rdm;
    logic       rwm;
    logic [4:0] rdw;
    logic       rww;
    logic [9:0] exp;
  } vec_t;
  vec_t vecs[13];

  function automatic vec_t mk(logic [4:0] r1d, r2d, r1e, r2e, rde, logic mr, pc,
                              logic [4:0] rdm, logic rwm, logic [4:0] rdw, logic rww, logic [9:0] exp);
    mk = '{r1d, r2d, r1e, r2e, rde, mr, pc, rdm, rwm, rdw, rww, exp};
  endfunction

  function automatic logic [9:0] ctl();
    ctl = {StallF, StallD, FlushD, ID_EX_Stall, ID_EX_Flush, EX_MEM_Flush, ForwardAE, ForwardBE};
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    {rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rdE, rdM, rdW} = '0;
    {MemReadE, MulDivE, PCSrcE, RegWriteM, RegWriteW, md_done} = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    rst_n = 1'b0;
    #1;
    chk("reset_ctl", int'(ctl()), 0);
    chk("reset_cnt", int'({stall_cnt, flush_cnt, md_timeout, md_start}), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_in();
    #1;
    chk("reset0_ctl", int'(ctl()), 0);
    chk("reset0_cnt", int'({stall_cnt, flush_cnt, md_timeout, md_start}), 0);
    // {StallF,StallD,FlushD,ID_EX_Stall,ID_EX_Flush,EX_MEM_Flush,FwdA,FwdB}
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b000000_0000);
    vecs[1]  = mk(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 10'b110010_0000);
    vecs[2]  = mk(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 10'b110010_0000);
    vecs[3]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10'b000000_0000);
    vecs[4]  = mk(5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 10'b000000_0000);
    vecs[5]  = mk(5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 10'b001010_0000);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10'b001010_0000);
    vecs[7]  = mk(0, 0, 3, 0, 0, 0, 0, 3, 1, 3, 1, 10'b000000_1000);
    vecs[8]  = mk(0, 0, 3, 0, 0, 0, 0, 3, 0, 3, 1, 10'b000000_0100);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 10'b000000_0000);
    vecs[10] = mk(0, 0, 0, 7, 0, 0, 0, 0, 0, 7, 1, 10'b000000_0001);
    vecs[11] = mk(0, 0, 7, 7, 0, 0, 0, 7, 1, 7, 1, 10'b000000_1010);
    vecs[12] = mk(0, 0, 4, 9, 0, 0, 0, 4, 1, 9, 1, 10'b000000_1001);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      {rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rdE} =
        {vecs[i].r1d, vecs[i].r2d, vecs[i].r1e, vecs[i].r2e, vecs[i].rde};
      {MemReadE, PCSrcE, rdM, RegWriteM, rdW, RegWriteW} =
        {vecs[i].mr, vecs[i].pc, vecs[i].rdm, vecs[i].rwm, vecs[i].rdw, vecs[i].rww};
      #1;
      chk($sformatf("vec%0d", i), int'(ctl()), int'(vecs[i].exp));
    end

    // load-use counts one stall; redirect over load-use counts one flush only
    do_reset();
    @(negedge clk);
    rdE = 5; MemReadE = 1; rs1_addrD = 5;
    @(posedge clk); #1;
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    @(negedge clk);
    PCSrcE = 1;
    #1;
    chk("redir_lu_ctl", int'(ctl()), 10'b001010_0000);
    @(posedge clk); #1;
    chk("redir_cnts", int'({stall_cnt, flush_cnt}), {4'd1, 4'd1});

    // handshake: md_done 4 cycles after md_start, PCSrcE ignored during hold
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      MulDivE = 1; md_done = (c == 4); PCSrcE = (c == 2);
      #1;
      chk($sformatf("hs_start%0d", c), int'(md_start), int'(c == 0));
      chk($sformatf("hs_ctl%0d", c), int'(ctl()), (c < 4) ? 10'b110101_0000 : 10'b000000_0000);
    end
    @(negedge clk);
    MulDivE = 0; md_done = 1;
    #1;
    chk("hs_idle_done", int'({ctl(), md_start}), 0);
    chk("hs_cnts", int'({stall_cnt, flush_cnt}), {4'd4, 4'd0});

    // back-to-back minimum-length mul/div
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      MulDivE = 1; md_done = c[0];
      #1;
      chk($sformatf("b2b%0d", c), int'({md_start, StallF}), c[0] ? 0 : 3);
    end
    @(negedge clk);
    MulDivE = 0; md_done = 0;
    #1;
    chk("b2b_cnt", int'(stall_cnt), 2);

    // timeout with MD_MAX_CYCLES=8
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      MulDivE = 1;
      #1;
      chk($sformatf("to_hold%0d", c), int'({StallF, md_timeout}), (c < 8) ? 2 : 0);
    end
    @(negedge clk);
    MulDivE = 0;
    #1;
    chk("to_flag", int'({md_timeout, StallF, md_start}), 4);
    MulDivE = 1;
    #1;
    chk("to_idle_probe", int'(md_start), 1);
    MulDivE = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("to_sticky", int'(md_timeout), 1);

    // reset in the 3rd BUSY cycle
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      MulDivE = 1;
    end
    @(negedge clk);
    rst_n = 0; MulDivE = 0;
    #1;
    chk("rst_busy_ctl", int'({ctl(), md_start}), 0);
    chk("rst_busy_cnt", int'({stall_cnt, flush_cnt, md_timeout}), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_after", int'({StallF, md_start}), 0);
    MulDivE = 1;
    #1;
    chk("rst_idle_probe", int'(md_start), 1);
    MulDivE = 0;

    // counter saturation at 2^CNT_W-1
    do_reset();
    @(negedge clk);
    rdE = 5; MemReadE = 1; rs1_addrD = 5;
    repeat (20) @(negedge clk);
    PCSrcE = 1;
    repeat (20) @(negedge clk);
    #1;
    chk("sat_cnts", int'({stall_cnt, flush_cnt}), 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage pipeline. It generates the stall and flush controls for the IF/ID and ID/EX pipeline registers and the bubble control for EX/MEM. It also produces the EX-stage forwarding selects and runs the start/done handshake with the multi-cycle mul/div unit. It sits beside the datapath, takes register addresses and control bits from ID/EX/MEM/WB, and keeps saturating stall/flush counters for performance monitoring.

## Interface
- MD_MAX_CYCLES, 64: cycles the mul/div unit may stay busy before a timeout (≥2)
- CNT_W, 16: width of the performance counters
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs1_addrD, rs2_addrD  in  5  source registers of the instruction in ID
- rs1_addrE, rs2_addrE  in  5  source registers of the instruction in EX
- rdE  in  5  destination of the instruction in EX
- MemReadE  in  1  the instruction in EX is a load
- MulDivE  in  1  the instruction in EX is a multi-cycle mul/div
- PCSrcE  in  1  taken branch, jump or jalr resolved in EX
- rdM, RegWriteM  in  5, 1  MEM-stage destination and its write enable
- rdW, RegWriteW  in  5, 1  WB-stage destination and its write enable
- md_done  in  1  mul/div result valid (single-cycle pulse)
- StallF  out  1  hold the PC
- StallD  out  1  hold IF/ID
- FlushD  out  1  clear IF/ID to a NOP
- ID_EX_Stall  out  1  hold ID/EX
- ID_EX_Flush  out  1  load a bubble into ID/EX
- EX_MEM_Flush  out  1  load a bubble into EX/MEM
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 = register file, 01 = WB, 10 = MEM
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_timeout  out  1  sticky error flag, set when the mul/div unit exceeds MD_MAX_CYCLES
- stall_cnt  out  CNT_W  count of cycles with StallF=1, saturating
- flush_cnt  out  CNT_W  count of redirect cycles, saturating

## Operation
- The FSM has two states, IDLE and BUSY. It also holds md_cnt, a counter of log2(MD_MAX_CYCLES) bits.
- Forwarding is purely combinational:
  - ForwardAE=10 when RegWriteM, rdM≠0 and rdM==rs1_addrE.
  - Otherwise ForwardAE=01 when RegWriteW, rdW≠0 and rdW==rs1_addrE.
  - Otherwise ForwardAE=00.
  - ForwardBE follows the same rules using rs2_addrE. MEM always wins over WB.
- Load-use is `lu` = MemReadE ∧ rdE≠0 ∧ (rdE==rs1_addrD ∨ rdE==rs2_addrD).
- Output priority within a cycle, highest first:
  1. **mul/div hold**: state BUSY with md_done=0, or state IDLE with MulDivE=1. Outputs StallF=StallD=ID_EX_Stall=EX_MEM_Flush=1.
  2. **redirect**: PCSrcE=1. Outputs FlushD=ID_EX_Flush=1 and no stall.
  3. **load-use**: `lu`=1. Outputs StallF=StallD=ID_EX_Flush=1.
  4. **none**: every control output is 0.
- A redirect in the same cycle as a load-use is treated as a redirect only; the load-use stall is dropped.
- FSM transitions:
  - IDLE, MulDivE=1: md_start=1, md_cnt←0, go to BUSY.
  - IDLE, otherwise: md_start=0.
  - BUSY, md_done=1: release the hold this cycle (rule 1 inactive, so EX/MEM captures the result), go to IDLE.
  - BUSY, md_done=0 and md_cnt==MD_MAX_CYCLES−1: md_timeout←1, release the hold this cycle, go to IDLE.
  - BUSY, otherwise: md_cnt←md_cnt+1.
- PCSrcE is ignored while rule 1 is active.
- stall_cnt increments on every cycle with StallF=1. flush_cnt increments on every cycle where rule 2 applies. Both hold at 2^CNT_W−1.
- md_timeout clears only on reset.

## Timing
- Reset values: state=IDLE, md_cnt=0, md_timeout=0, stall_cnt=flush_cnt=0. With MulDivE=0, all combinational outputs are 0 during reset.
- All control and forwarding outputs are combinational from the current state and current inputs, with zero latency.
- md_start is asserted for exactly one cycle per mul/div instruction. It cannot re-fire until the pipeline has advanced out of the release cycle.
- Minimum mul/div occupancy is 2 cycles: the start cycle plus a BUSY cycle with md_done. The hold covers the start cycle and every BUSY cycle before md_done.
- Back-to-back mul/div: the release cycle is in BUSY, so the second instruction is seen in IDLE on the next cycle and gets its own md_start.
- md_done arriving while in IDLE is ignored.
- Reset asserted mid-BUSY forces IDLE asynchronously. No md_start is issued afterwards for the aborted operation.

## Test plan
- **Load-use**: rdE=5, MemReadE=1, rs1_addrD=5 → StallF=StallD=ID_EX_Flush=1 for 1 cycle, stall_cnt=1; rdE=0 → no stall.
- **Redirect over load-use**: PCSrcE=1 together with the load-use condition → FlushD=ID_EX_Flush=1, StallF=0, flush_cnt=1, stall_cnt unchanged.
- **Forwarding**: rdM=rdW=rs1_addrE=3 with both write enables set → ForwardAE=10; RegWriteM=0 → 01; rdM=rdW=0 → 00.
- **Mul/div handshake**: MulDivE=1, md_done pulsed 4 cycles after md_start → md_start for 1 cycle, hold for 4 cycles, released on the md_done cycle, stall_cnt=4.
- **Timeout**: MD_MAX_CYCLES=8, md_done never asserted → hold for 8 cycles, md_timeout=1 from then on, FSM in IDLE.
- **Reset mid-BUSY**: assert rst_n=0 in the 3rd BUSY cycle → all outputs 0, counters 0; after release with MulDivE=0 the FSM stays IDLE.
